lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
Load/store stage directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data, and runs one data-bus transaction per request with a valid/ack handshake. It aligns and byte-enables store data, then extracts and sign- or zero-extends load data for writeback. Misaligned and illegal requests return an error without touching the bus.

Parameters:
TIMEOUT_CYCLES, 16, cycles to wait for bus_ack before aborting (used only when LSU_TIMEOUT_EN is defined)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
req_valid  input  1  EX stage presents a memory op
req_ready  output  1  stage can accept; high only in IDLE
mem_we  input  1  1=store, 0=load
mem_op  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  effective address (ALU result C)
wdata  input  32  store data (rs2)
bus_req  output  1  bus transaction request, registered
bus_we  output  1  bus write
bus_addr  output  32  word address, {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-aligned store data
bus_ack  input  1  bus completes transaction this cycle
bus_rdata  input  32  read data, valid with bus_ack
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores/errors
resp_err  output  1  valid with resp_valid; misaligned/illegal/timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except req_ready=1. Any in-flight bus_req drops immediately; the pending op is discarded with no response.
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid at the clock edge, latch the request.
  - Legal and aligned -> BUSY; bus_* registered and driven from the next cycle.
  - Otherwise -> RESP with err=1.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Also applies to stores (SB any, SH, SW).
- Illegal: mem_op in {011,110,111}; store with mem_op in {100,101}.
- BUSY: bus_req=1. bus_we/addr/be/wdata held stable until the ack cycle. On bus_ack: capture formatted rdata, drop bus_req at the next edge, go to RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err, then -> IDLE. req_ready=0 in BUSY and RESP.
- Latency: accept at edge N -> bus_req high in cycle N+1 -> ack in the same cycle -> resp_valid in cycle N+2. Each wait-state adds one cycle. Error path: resp_valid in cycle N+1.
- bus_ack outside BUSY is ignored.
- Store enables and data (o = addr[1:0]):
  - SB: be = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
  - SH: be = o[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111, wdata unchanged.
- Load extraction: byte = bus_rdata[8*o +: 8], half = bus_rdata[16*o[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Loads drive bus_be per size, same as stores.
- Store response: resp_rdata=0, resp_err=0.

Optional Feature:
- LSU_TIMEOUT_EN defined: a counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack: drop bus_req, go to RESP with resp_err=1, resp_rdata=0.
  - An ack in the same cycle as the limit wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely.

Test Plan:
- LW addr=0x100, bus_rdata=0xDEADBEEF, ack in first bus cycle -> bus_addr=0x100, be=1111, resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF, err=0.
- LB addr=0x103, rdata=0x80FFFFFF, ack after 3 waits -> be=1000, resp_rdata=0xFFFFFF80; then LBU with the same inputs -> 0x00000080; latency 5.
- SH addr=0x202, wdata=0x1234ABCD -> bus_we=1, bus_addr=0x200, be=1100, bus_wdata=0xABCDABCD, resp_rdata=0, err=0.
- LW addr=0x101 and mem_op=011 -> bus_req never asserts, resp_valid 1 cycle after accept with err=1.
- Assert rst_n=0 mid-BUSY -> bus_req and all outputs 0 immediately, no resp_valid after release, req_ready=1.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req high exactly 4 cycles, then resp_valid with err=1; ack on cycle 4 -> normal response.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: request, data-bus and response signals of the load/store stage.
// slave is the stage's side; master is the side facing it (EX stage, memory bus, writeback).
interface lsu_mem_stage_if;
  // request from EX
  logic        req_valid;
  logic        req_ready;
  logic        mem_we;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  // data bus
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  // writeback response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport slave (
    input  req_valid, mem_we, mem_op, addr, wdata, bus_ack, bus_rdata,
    output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, mem_we, mem_op, addr, wdata, bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage after the ALU. One bus transaction per request,
// store lane alignment / byte enables, load extraction with sign/zero extension.
// Optional macro LSU_TIMEOUT_EN: abort a bus transaction after TIMEOUT_CYCLES
// cycles without bus_ack and answer with an error.

// Per-byte-lane store formatting: enable bit and the byte of rs2 that lands here.
module lsu_be_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,   // 00 byte, 01 half, 10 word
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  data
);
  localparam logic [1:0] LN = 2'(LANE);

  // byte replicates rs2[7:0], half replicates rs2[15:0], word passes through
  always_comb begin
    be   = 1'b0;
    data = wdata[7:0];
    case (size)
      2'b00: begin
        be   = (off == LN);
        data = wdata[7:0];
      end
      2'b01: begin
        be   = (off[1] == LN[1]);
        data = LN[0] ? wdata[15:8] : wdata[7:0];
      end
      default: begin
        be   = 1'b1;
        data = wdata[8*LANE +: 8];
      end
    endcase
  end
endmodule

module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             rst_n,
  lsu_mem_stage_if.slave  io
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // what must survive until the load data comes back
  typedef struct packed {
    logic       we;
    logic [2:0] op;
    logic [1:0] off;
  } req_t;

  state_t state;
  req_t   rq;

  logic [NUM_LANES-1:0]      st_be;
  logic [NUM_LANES-1:0][7:0] st_data;
  logic                      illegal, misal;
  logic [31:0]               ld_shift, ld_data;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt;
`endif

  // store lanes are formatted from the live request and registered on accept
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_be_lane #(.LANE(g)) u_lane (
      .size  (io.mem_op[1:0]),
      .off   (io.addr[1:0]),
      .wdata (io.wdata),
      .be    (st_be[g]),
      .data  (st_data[g])
    );
  end

  // reject unsupported encodings and accesses not aligned to their size
  always_comb begin
    illegal = (io.mem_op == 3'b011) || (io.mem_op[2:1] == 2'b11) ||
              (io.mem_we && io.mem_op[2]);
    misal   = ((io.mem_op[1:0] == 2'b01) && io.addr[0]) ||
              ((io.mem_op[1:0] == 2'b10) && (io.addr[1:0] != 2'b00));
  end

  // load extraction from the latched offset/size; W and unused codes pass through
  always_comb begin
    ld_shift = io.bus_rdata >> {rq.off, 3'b000};
    ld_byte  = ld_shift[7:0];
    ld_half  = rq.off[1] ? io.bus_rdata[31:16] : io.bus_rdata[15:0];
    case (rq.op)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = io.bus_rdata;
    endcase
  end

  // control FSM; every output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rq            <= '0;
      io.req_ready  <= 1'b1;
      io.bus_req    <= 1'b0;
      io.bus_we     <= 1'b0;
      io.bus_addr   <= '0;
      io.bus_be     <= '0;
      io.bus_wdata  <= '0;
      io.resp_valid <= 1'b0;
      io.resp_rdata <= '0;
      io.resp_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tcnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (io.req_valid) begin
            rq           <= '{we: io.mem_we, op: io.mem_op, off: io.addr[1:0]};
            io.req_ready <= 1'b0;
            if (illegal || misal) begin
              // error answers straight away, the bus never sees it
              state         <= RESP;
              io.resp_valid <= 1'b1;
              io.resp_err   <= 1'b1;
              io.resp_rdata <= '0;
            end else begin
              state        <= BUSY;
              io.bus_req   <= 1'b1;
              io.bus_we    <= io.mem_we;
              io.bus_addr  <= {io.addr[31:2], 2'b00};
              io.bus_be    <= st_be;
              io.bus_wdata <= st_data;
`ifdef LSU_TIMEOUT_EN
              tcnt         <= '0;
`endif
            end
          end
        end
        BUSY: begin
          if (io.bus_ack) begin
            // ack wins even on the cycle the timeout would fire
            state         <= RESP;
            io.bus_req    <= 1'b0;
            io.bus_we     <= 1'b0;
            io.bus_addr   <= '0;
            io.bus_be     <= '0;
            io.bus_wdata  <= '0;
            io.resp_valid <= 1'b1;
            io.resp_err   <= 1'b0;
            io.resp_rdata <= rq.we ? 32'd0 : ld_data;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state         <= RESP;
            io.bus_req    <= 1'b0;
            io.bus_we     <= 1'b0;
            io.bus_addr   <= '0;
            io.bus_be     <= '0;
            io.bus_wdata  <= '0;
            io.resp_valid <= 1'b1;
            io.resp_err   <= 1'b1;
            io.resp_rdata <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state         <= IDLE;
          io.resp_valid <= 1'b0;
          io.resp_err   <= 1'b0;
          io.resp_rdata <= '0;
          io.req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: scoreboard bench for lsu_mem_stage. Expected responses are queued
// on accept and compared (data, error, latency) when resp_valid shows up.
module tb_lsu_mem_stage;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  lsu_mem_stage_if io ();

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    longint      t;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // response monitor: every resp_valid must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && io.resp_valid) begin
      if (sbq.size() == 0) chk("spurious_resp", 32'(io.resp_valid), 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_rdata", io.resp_rdata, e.rdata);
        chk("resp_err", 32'(io.resp_err), 32'(e.err));
        chk("resp_lat", 32'(int'(($time - e.t + 5) / 10)), 32'(e.lat));
      end
    end
  end

  task automatic accept(input logic we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input bit push, input logic [31:0] erd,
                        input logic eerr, input int lat);
    exp_t e;
    @(negedge clk);
    chk("req_ready", 32'(io.req_ready), 32'd1);
    io.req_valid = 1'b1;
    io.mem_we    = we;
    io.mem_op    = op;
    io.addr      = a;
    io.wdata     = wd;
    @(posedge clk);
    if (push) begin
      e.rdata = erd; e.err = eerr; e.lat = lat; e.t = longint'($time);
      sbq.push_back(e);
    end
    #1;
    io.req_valid = 1'b0;
    io.addr      = $urandom;
    io.wdata     = $urandom;
    io.mem_we    = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("resp_missing", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  // one full transaction; waits<0 is never used, errors are flagged by eerr
  task automatic do_op(input logic we, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd, input logic eerr);
    accept(we, op, a, wd, 1'b1, erd, eerr, eerr ? 1 : 2 + waits);
    if (eerr) begin
      @(negedge clk);
      chk("no_bus_req", 32'(io.bus_req), 32'd0);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        chk("bus_req", 32'(io.bus_req), 32'd1);
        chk("ready_busy", 32'(io.req_ready), 32'd0);
        if (w == 0 || w == waits) begin
          chk("bus_we", 32'(io.bus_we), 32'(we));
          chk("bus_addr", io.bus_addr, {a[31:2], 2'b00});
          chk("bus_be", 32'(io.bus_be), 32'(ebe));
          if (we) chk("bus_wdata", io.bus_wdata, ewd);
        end
        io.bus_ack   = (w == waits);
        io.bus_rdata = (w == waits) ? rd : $urandom;
      end
      @(posedge clk);
      #1;
      io.bus_ack   = 1'b0;
      io.bus_rdata = $urandom;
      @(negedge clk);
      chk("bus_req_drop", 32'(io.bus_req), 32'd0);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    io.req_valid = 1'b0; io.mem_we = 1'b0; io.mem_op = 3'b0;
    io.addr = '0; io.wdata = '0; io.bus_ack = 1'b0; io.bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(io.req_ready), 32'd1);
    chk("rst_bus_req", 32'(io.bus_req), 32'd0);
    chk("rst_resp_valid", 32'(io.resp_valid), 32'd0);
    chk("rst_resp_rdata", io.resp_rdata, 32'd0);
    chk("rst_bus_be", 32'(io.bus_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   we  op      addr          wdata         rdata         w  be       bus_wdata     resp_rdata    err
    do_op(0, 3'b010, 32'h100,      32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
    do_op(0, 3'b000, 32'h103,      32'h0,        32'h80FFFFFF, 3, 4'b1000, 32'h0,        32'hFFFFFF80, 0);
    do_op(0, 3'b100, 32'h103,      32'h0,        32'h80FFFFFF, 3, 4'b1000, 32'h0,        32'h00000080, 0);
    do_op(1, 3'b001, 32'h202,      32'h1234ABCD, 32'hFFFFFFFF, 0, 4'b1100, 32'hABCDABCD, 32'h0,        0);
    do_op(1, 3'b000, 32'h201,      32'h77665555, 32'h0,        1, 4'b0010, 32'h55555555, 32'h0,        0);
    do_op(1, 3'b010, 32'hC0000300, 32'hCAFEF00D, 32'h0,        2, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
    do_op(1, 3'b001, 32'h200,      32'h00009876, 32'h0,        0, 4'b0011, 32'h98769876, 32'h0,        0);
    do_op(0, 3'b001, 32'h102,      32'h0,        32'h80017FFF, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0);
    do_op(0, 3'b101, 32'h100,      32'h0,        32'h80017FFF, 1, 4'b0011, 32'h0,        32'h00007FFF, 0);
    do_op(0, 3'b000, 32'h101,      32'h0,        32'h00007F00, 0, 4'b0010, 32'h0,        32'h0000007F, 0);
    do_op(0, 3'b001, 32'h100,      32'h0,        32'h12348000, 0, 4'b0011, 32'h0,        32'hFFFF8000, 0);
    // errors: misaligned and illegal, bus untouched, response one cycle after accept
    do_op(0, 3'b010, 32'h101,      32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
    do_op(0, 3'b011, 32'h100,      32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
    do_op(0, 3'b001, 32'h103,      32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
    do_op(1, 3'b100, 32'h100,      32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
    do_op(1, 3'b010, 32'h102,      32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);
    do_op(0, 3'b111, 32'h100,      32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1);

    // ack while idle must not produce anything
    @(negedge clk);
    io.bus_ack = 1'b1; io.bus_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    io.bus_ack = 1'b0;
    chk("idle_ack_bus_req", 32'(io.bus_req), 32'd0);
    chk("idle_ack_ready", 32'(io.req_ready), 32'd1);
    repeat (2) @(negedge clk);

`ifdef LSU_TIMEOUT_EN
    begin
      int hi = 0;
      accept(0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0, 1'b1, TO + 1);
      for (int i = 0; i < TO + 8 && sbq.size() != 0; i++) begin
        @(negedge clk);
        if (io.bus_req) hi++;
      end
      chk("to_bus_cycles", 32'(hi), 32'(TO));
      drain();
    end
    // ack on the limit cycle completes normally
    do_op(0, 3'b010, 32'h404, 32'h0, 32'h600DF00D, TO - 1, 4'b1111, 32'h0, 32'h600DF00D, 0);
`else
    // without the timeout a long wait still completes
    do_op(0, 3'b010, 32'h404, 32'h0, 32'h600DF00D, TO + 4, 4'b1111, 32'h0, 32'h600DF00D, 0);
`endif

    // reset while BUSY: outputs clear at once, no response afterwards
    accept(0, 3'b010, 32'h500, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    chk("pre_rst_bus_req", 32'(io.bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_req", 32'(io.bus_req), 32'd0);
    chk("mid_rst_bus_addr", io.bus_addr, 32'd0);
    chk("mid_rst_bus_be", 32'(io.bus_be), 32'd0);
    chk("mid_rst_ready", 32'(io.req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(io.resp_valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_bus_req", 32'(io.bus_req), 32'd0);
    chk("post_rst_ready", 32'(io.req_ready), 32'd1);

    // still functional after the reset
    do_op(0, 3'b000, 32'h102, 32'h0, 32'h00AB0000, 0, 4'b0100, 32'h0, 32'hFFFFFFAB, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
